// File: rtl/write_back_slice_accum.sv
// ============================================================================
// Module   : write_back_slice_accum
// Brief    : Accumulates bit, part-select and member writes into an 8-bit
//            shadow and publishes it as a {hi,lo} pair through a valid/ready
//            output register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module write_back_slice_accum #(
   parameter int unsigned COUNT_W   = 4,
   parameter logic [7:0]  CLEAR_VAL = 8'h00
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         op,
   input  logic [2:0]         idx,
   input  logic [7:0]         data,
   input  logic               commit,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [7:0]         out_data,
   output logic [COUNT_W-1:0] out_count
);

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam logic [1:0] OP_CLEAR = 2'b00;
   localparam logic [1:0] OP_BIT   = 2'b01;
   localparam logic [1:0] OP_PART  = 2'b10;
   localparam logic [1:0] OP_MEMB  = 2'b11;

   localparam logic [COUNT_W-1:0] CNT_MAX = '1;
   localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

   state_t               state_q, state_d;
   logic [7:0]           shadow_q, shadow_d;
   logic [COUNT_W-1:0]   wcount_q, wcount_d;
   logic                 out_valid_q, out_valid_d;
   logic [7:0]           out_data_q, out_data_d;
   logic [COUNT_W-1:0]   out_count_q, out_count_d;

   logic [7:0]           merged;
   logic [COUNT_W-1:0]   wcount_upd;
   logic                 accept;
   logic                 unused_data_hi;

   assign unused_data_hi = ^data[7:4];

   // A pending, unaccepted word also blocks input so a commit can never
   // overwrite it, even in the cycle before the state register reaches HOLD.
   assign in_ready  = (state_q == ACCUM) && !(out_valid_q && !out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_count = out_count_q;

   always_comb begin
      merged     = shadow_q;
      wcount_upd = (wcount_q == CNT_MAX) ? wcount_q : wcount_q + CNT_ONE;
      unique case (op)
         OP_CLEAR: begin
            merged     = CLEAR_VAL;
            wcount_upd = '0;
         end
         OP_BIT: merged[idx] = data[0];
         OP_PART: begin
            merged[idx] = data[0];
            // The upper bit of a pair starting at bit 7 falls off the word.
            if (idx != 3'd7) begin
               merged[idx + 3'd1] = data[1];
            end
         end
         OP_MEMB: begin
            if (idx[0]) begin
               merged[7:4] = data[3:0];
            end else begin
               merged[3:0] = data[3:0];
            end
         end
         default: merged = shadow_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      shadow_d    = shadow_q;
      wcount_d    = wcount_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;

      if (accept && commit) begin
         out_data_d  = merged;
         out_count_d = wcount_upd;
         out_valid_d = 1'b1;
         shadow_d    = CLEAR_VAL;
         wcount_d    = '0;
      end else begin
         if (accept) begin
            shadow_d = merged;
            wcount_d = wcount_upd;
         end
         if (out_ready) begin
            out_valid_d = 1'b0;
         end
      end

      unique case (state_q)
         ACCUM: if (out_valid_q && !out_ready && !(accept && commit)) state_d = HOLD;
         HOLD:  if (out_ready) state_d = ACCUM;
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ACCUM;
         shadow_q    <= CLEAR_VAL;
         wcount_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
         out_count_q <= '0;
      end else begin
         state_q     <= state_d;
         shadow_q    <= shadow_d;
         wcount_q    <= wcount_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_write_back_slice_accum.sv
// ============================================================================
// Module   : tb_write_back_slice_accum
// Brief    : Directed self-checking bench for write_back_slice_accum.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_write_back_slice_accum;

   localparam int unsigned COUNT_W = 4;

   logic               clk;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [1:0]         op;
   logic [2:0]         idx;
   logic [7:0]         data;
   logic               commit;
   logic               out_valid;
   logic               out_ready;
   logic [7:0]         out_data;
   logic [COUNT_W-1:0] out_count;

   int errors = 0;
   int checks = 0;

   write_back_slice_accum #(
      .COUNT_W   (COUNT_W),
      .CLEAR_VAL (8'h00)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .idx       (idx),
      .data      (data),
      .commit    (commit),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One accepted request: inputs held across a single rising edge.
   task automatic req(input logic [1:0] o, input logic [2:0] i, input logic [7:0] d, input logic c);
      in_valid = 1'b1;
      op       = o;
      idx      = i;
      data     = d;
      commit   = c;
      tick();
      in_valid = 1'b0;
      commit   = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      op        = 2'b00;
      idx       = 3'd0;
      data      = 8'h00;
      commit    = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;

      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out_data",  32'(out_data),  32'h00);
      chk("reset_out_count", 32'(out_count), 32'd0);
      chk("reset_in_ready",  32'(in_ready),  32'd1);

      // Bit write then part-select write with commit
      req(2'b01, 3'd3, 8'h01, 1'b0);
      chk("no_commit_out_valid", 32'(out_valid), 32'd0);
      req(2'b10, 3'd4, 8'h03, 1'b1);
      chk("t1_out_valid", 32'(out_valid), 32'd1);
      chk("t1_out_data",  32'(out_data),  32'h38);
      chk("t1_out_count", 32'(out_count), 32'd2);

      // Part-select at idx 7: bit 8 dropped, no wrap
      req(2'b10, 3'd7, 8'h03, 1'b1);
      chk("t2_out_valid", 32'(out_valid), 32'd1);
      chk("t2_out_data",  32'(out_data),  32'h80);
      chk("t2_out_count", 32'(out_count), 32'd1);

      // Member writes
      req(2'b11, 3'd1, 8'hFA, 1'b0);
      req(2'b11, 3'd0, 8'h05, 1'b1);
      chk("t3_out_data",  32'(out_data),  32'hA5);
      chk("t3_out_count", 32'(out_count), 32'd2);

      // Commit then downstream stall
      req(2'b01, 3'd0, 8'h01, 1'b1);
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_out_data",  32'(out_data),  32'h01);
         chk("stall_out_count", 32'(out_count), 32'd1);
         chk("stall_in_ready",  32'(in_ready),  32'd0);
      end
      // A request offered during the stall must be ignored
      in_valid = 1'b1; op = 2'b01; idx = 3'd6; data = 8'h01; commit = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0; commit = 1'b0;
      chk("release_out_valid", 32'(out_valid), 32'd0);
      chk("release_in_ready",  32'(in_ready),  32'd1);
      chk("release_out_data",  32'(out_data),  32'h01);

      // Writes, clear, then a single write with commit
      req(2'b01, 3'd1, 8'h01, 1'b0);
      req(2'b01, 3'd2, 8'h01, 1'b0);
      req(2'b01, 3'd3, 8'h01, 1'b0);
      req(2'b00, 3'd0, 8'h00, 1'b0);
      req(2'b01, 3'd0, 8'h01, 1'b1);
      chk("clear_out_data",  32'(out_data),  32'h01);
      chk("clear_out_count", 32'(out_count), 32'd1);

      // Saturating counter
      for (int k = 0; k < 20; k++) begin
         req(2'b01, 3'd5, 8'h01, 1'b0);
      end
      chk("sat_out_valid", 32'(out_valid), 32'd0);
      req(2'b01, 3'd6, 8'h01, 1'b1);
      chk("sat_out_data",  32'(out_data),  32'h60);
      chk("sat_out_count", 32'(out_count), 32'd15);

      // Reset while holding a word
      req(2'b11, 3'd0, 8'h07, 1'b1);
      out_ready = 1'b0;
      tick();
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_data", 32'(out_data), 32'h07);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rst_hold_out_valid", 32'(out_valid), 32'd0);
      chk("rst_hold_out_data",  32'(out_data),  32'h00);
      chk("rst_hold_out_count", 32'(out_count), 32'd0);
      chk("rst_hold_in_ready",  32'(in_ready),  32'd1);
      req(2'b00, 3'd0, 8'h00, 1'b1);
      chk("post_rst_out_valid", 32'(out_valid), 32'd1);
      chk("post_rst_out_data",  32'(out_data),  32'h00);
      chk("post_rst_out_count", 32'(out_count), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/write_back_slice_accum.md
Name: write_back_slice_accum

Overview:
- Sequential stage directly downstream of the combinational slice write-back logic.
- Applies a stream of bit, indexed-part-select and struct-member writes to an 8-bit shadow register.
- On commit, publishes the merged value as a wb_pair_t {hi[3:0], lo[3:0]} through a valid/ready output register.
- Serves as the clocked counterpart fixture for exercising always_ff write-back of static, dynamic and member targets.

Parameters:
- COUNT_W, 4, width of the saturating write counter reported with each committed word.
- CLEAR_VAL, 8'h00, value loaded into the shadow register by reset, by a clear op, and after every accepted commit.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  write/commit request valid
- in_ready  output  1  stage can accept a request this cycle
- op  input  2  00 clear, 01 bit write, 10 two-bit part-select write, 11 member write
- idx  input  3  bit index (op 01/10); idx[0] selects member for op 11 (1 = hi, 0 = lo)
- data  input  8  write data
- commit  input  1  publish the shadow after applying this request's op
- out_valid  output  1  committed word available
- out_ready  input  1  downstream accepts the committed word
- out_data  output  8  committed word, wb_pair_t layout: hi = [7:4], lo = [3:0]
- out_count  output  COUNT_W  writes merged into out_data since the previous commit, saturating

Behaviour:
- Clocking and reset:
  - One clock domain; every register updates on posedge clk.
  - When rst_n = 0 at an edge: shadow = CLEAR_VAL, wcount = 0, out_valid = 0, out_data = 8'h00, out_count = 0, state = ACCUM.
  - Reset overrides any in-flight handshake; a word held in HOLD is discarded.
- States:
  - ACCUM: in_ready = 1.
  - HOLD: in_ready = 0.
- Request acceptance:
  - A request is accepted when in_valid && in_ready.
  - op is applied to the shadow combinationally, producing the "merged" value.
- Op 00 (clear):
  - merged = CLEAR_VAL.
  - wcount resets to 0; a clear does not count as a write.
- Op 01 (bit write):
  - merged = shadow with bit idx = data[0].
- Op 10 (part-select write):
  - Bit idx = data[0]; bit idx+1 = data[1].
  - When idx = 7, bit 8 is out of range: that bit is dropped, no wrap to bit 0, and bit 7 is still written.
- Op 11 (member write):
  - idx[0] = 1: hi = data[3:0].
  - idx[0] = 0: lo = data[3:0].
  - data[7:4] and idx[2:1] are ignored.
- Write counting:
  - Ops 01, 10 and 11 increment wcount, saturating at 2^COUNT_W - 1.
- Accepted request with commit = 0:
  - shadow <= merged.
- Accepted request with commit = 1:
  - out_data <= merged; out_count <= the updated wcount.
  - out_valid <= 1; shadow <= CLEAR_VAL; wcount <= 0.
  - Latency: out_valid rises on the edge that accepts the request, so it is visible in the next cycle.
- Commit, out_valid = 0 or out_ready = 1 in the accept cycle: the word loads directly and the state stays ACCUM.
- Commit, out_valid = 1 and out_ready = 0 in the accept cycle: the new word may not overwrite the pending word; this case cannot occur because in_ready is 0 in HOLD.
- Entering HOLD:
  - ACCUM -> HOLD at the edge where out_valid = 1 and out_ready = 0 and no commit is accepted.
  - Equivalently, in_ready = !(out_valid && !out_ready), registered as the state.
- HOLD -> ACCUM:
  - Occurs on the edge where out_ready = 1; out_valid <= 0 at that edge.
  - No input is accepted in that same cycle.
- ACCUM with out_valid && out_ready and a simultaneous commit: the old word retires and the new word loads; out_valid stays 1.
- Output stability: out_data and out_count remain stable while out_valid && !out_ready.
- Non-accepted cycles: the shadow holds.

Test Plan:
- Reset, then op01 idx=3 data=1, then op10 idx=4 data=2'b11 with commit, out_ready=1 -> next cycle out_valid=1, out_data=8'h38, out_count=2.
- op10 idx=7 data=8'h03 with commit -> out_data=8'h80 (bit 8 dropped, bit 0 untouched), out_count=1.
- op11 idx=1 data=8'hFA, then op11 idx=0 data=8'h05 with commit -> out_data=8'hA5, out_count=2.
- Commit with out_ready=0 -> in_ready=0 next cycle, out_data held across 3 stalled cycles; raise out_ready -> out_valid=0 and in_ready=1 the following cycle.
- Three op01 writes, op00 clear, one op01 idx=0 data=1 with commit -> out_data=8'h01, out_count=1; 20 writes then commit with COUNT_W=4 -> out_count=15.
- rst_n=0 for one edge while in HOLD -> out_valid=0, out_data=8'h00, in_ready=1, next commit with no prior writes yields out_data=CLEAR_VAL and out_count=0.
